ntt_zeta_sched: RTL

- Sequences the zeta ROM (256 x 23-bit, registered read, 1-cycle latency) for a full 256-point ML-DSA NTT or inverse NTT.
- Walks all 8 layers x 128 butterflies and drives the ROM enable and address.
- Emits each butterfly's coefficient address pair, aligned to the cycle in which the ROM data appears.
- Sits between the top-level NTT control and the butterfly unit / coefficient RAM.

---
 rtl/ntt_zeta_sched_if.sv | 25 ++
 rtl/ntt_zeta_sched.sv | 97 +++++++++
 2 files changed

// File: rtl/ntt_zeta_sched_if.sv
// ntt_zeta_sched_if: control, ROM-address and butterfly-descriptor bundle of the zeta scheduler.
interface ntt_zeta_sched_if;
   logic       start;
   logic       inverse;
   logic       stall;
   logic       rom_en;
   logic [7:0] rom_addr;
   logic       bf_valid;
   logic [7:0] bf_addr_a;
   logic [7:0] bf_addr_b;
   logic       bf_neg;
   logic [2:0] bf_layer;
   logic       busy;
   logic       done;

   modport master (
      output start, inverse, stall,
      input  rom_en, rom_addr, bf_valid, bf_addr_a, bf_addr_b, bf_neg, bf_layer, busy, done
   );

   modport slave (
      input  start, inverse, stall,
      output rom_en, rom_addr, bf_valid, bf_addr_a, bf_addr_b, bf_neg, bf_layer, busy, done
   );
endinterface

// File: rtl/ntt_zeta_sched.sv
// ntt_zeta_sched: walks 8 layers x 128 butterflies of a 256-point ML-DSA NTT, driving the zeta ROM.
// Inverse transform support is built only when NTT_ZETA_SCHED_INTT_EN is defined.
module ntt_zeta_sched #(
   parameter int N_LOG2 = 8,
   parameter int ZW     = 23
) (
   input logic             clk,
   input logic             rst_n,
   ntt_zeta_sched_if.slave bus
);
   if (N_LOG2 != 8 || ZW < 1) begin : g_bad_param
      $error("ntt_zeta_sched supports only N_LOG2 = 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t     state, nxt;
   logic [2:0] layer;
   logic [6:0] b;
   logic       issue, last;
   logic [2:0] s;
   logic [8:0] len, grp, j;
   logic [7:0] rom_idx;

`ifdef NTT_ZETA_SCHED_INTT_EN
   logic mode, neg_q;
   always_comb begin
      s       = mode ? layer : 3'd7 - layer;
      grp     = {2'b00, b} >> s;
      rom_idx = mode ? 8'((9'd256 >> layer) - 9'd1 - grp) : 8'((9'd1 << layer) + grp);
   end
   assign bus.bf_neg = neg_q;
`else
   logic unused_inverse;
   assign unused_inverse = bus.inverse;
   always_comb begin
      s       = 3'd7 - layer;
      grp     = {2'b00, b} >> s;
      rom_idx = 8'((9'd1 << layer) + grp);
   end
   assign bus.bf_neg = 1'b0;
`endif

   // j interleaves the group number above the in-group offset, leaving a gap of len
   always_comb begin
      len   = 9'd1 << s;
      j     = (grp << (4'(s) + 4'd1)) | ({2'b00, b} & (len - 9'd1));
      issue = state == RUN && !bus.stall;
      last  = layer == 3'd7 && b == 7'd127;
      nxt   = state == IDLE  ? (bus.start ? RUN : IDLE) :
              state == RUN   ? (issue && last ? DRAIN : RUN) :
              state == DRAIN ? DONE : IDLE;
   end

   assign bus.rom_en   = issue;
   assign bus.rom_addr = state == RUN ? rom_idx : 8'd0;
   assign bus.busy     = state != IDLE;
   assign bus.done     = state == DONE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         layer         <= '0;
         b             <= '0;
         bus.bf_valid  <= 1'b0;
         bus.bf_addr_a <= '0;
         bus.bf_addr_b <= '0;
         bus.bf_layer  <= '0;
`ifdef NTT_ZETA_SCHED_INTT_EN
         mode          <= 1'b0;
         neg_q         <= 1'b0;
`endif
      end else begin
         bus.bf_valid <= issue;
         if (state == IDLE && bus.start) begin
            layer <= '0;
            b     <= '0;
`ifdef NTT_ZETA_SCHED_INTT_EN
            mode  <= bus.inverse;
`endif
         end
         if (issue) begin
            b             <= b + 7'd1;
            layer         <= b == 7'd127 ? layer + 3'd1 : layer;
            bus.bf_addr_a <= 8'(j);
            bus.bf_addr_b <= 8'(j + len);
            bus.bf_layer  <= layer;
`ifdef NTT_ZETA_SCHED_INTT_EN
            neg_q         <= mode;
`endif
         end
      end
   end
endmodule
